// File: rtl/adc_dma_pkg.sv
// Shared definitions for the ADC DMA write path.
//  - wr_state_e     : write-engine FSM encodings (idle, address, data, response)
//  - AXI_BURST_INCR : AXI4 INCR burst type
//  - BOUNDARY_4K    : AXI4 bursts must not cross this byte boundary
//  - clog2()        : ceiling log2; derives awsize and the byte-to-beat shift
package adc_dma_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAw,
    StW,
    StB
  } wr_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int unsigned BOUNDARY_4K = 4096;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/adc_axi_dma_wr_engine_if.sv
// Bus bundle for the write engine: ADC AXI-Stream input plus the AXI4 write channels.
//  master : engine side (sinks the stream, drives AW/W, accepts B)
//  slave  : system side (stream source, DDR interconnect)
interface adc_axi_dma_wr_engine_if #(
  parameter int unsigned DATA_WDTH = 32,
  parameter int unsigned ADDR_WDTH = 32
);
  logic [DATA_WDTH-1:0]   s_axis_tdata;
  logic                   s_axis_tvalid;
  logic                   s_axis_tready;

  logic [ADDR_WDTH-1:0]   m_axi_awaddr;
  logic [7:0]             m_axi_awlen;
  logic [2:0]             m_axi_awsize;
  logic [1:0]             m_axi_awburst;
  logic                   m_axi_awvalid;
  logic                   m_axi_awready;

  logic [DATA_WDTH-1:0]   m_axi_wdata;
  logic [DATA_WDTH/8-1:0] m_axi_wstrb;
  logic                   m_axi_wlast;
  logic                   m_axi_wvalid;
  logic                   m_axi_wready;

  logic [1:0]             m_axi_bresp;
  logic                   m_axi_bvalid;
  logic                   m_axi_bready;

  modport master (
    input  s_axis_tdata, s_axis_tvalid,
    output s_axis_tready,
    output m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid,
    input  s_axis_tready,
    input  m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready
  );
endinterface

// File: rtl/adc_dma_burst_calc.sv
// Combinational burst sizing: blen = min(remaining, MAX_BURST, beats left in the 4 KB page).
//  addr      in  12          low byte-address bits (offset within the 4 KB page)
//  remaining in  LEN_WDTH    beats still to transfer in the job
//  blen      out 9           beats for the next burst (1..256 when remaining != 0)
module adc_dma_burst_calc
  import adc_dma_pkg::*;
#(
  parameter int unsigned LEN_WDTH  = 32,
  parameter int unsigned DATA_WDTH = 32,
  parameter int unsigned MAX_BURST = 64
) (
  input  logic [11:0]         addr,
  input  logic [LEN_WDTH-1:0] remaining,
  output logic [8:0]          blen
);
  localparam int unsigned BeatShift  = clog2(DATA_WDTH / 8);
  localparam logic [12:0] BeatsPer4k = 13'(BOUNDARY_4K >> BeatShift);

  logic [12:0] to_4k;

  always_comb begin
    to_4k = BeatsPer4k - 13'(addr >> BeatShift);
    blen  = 9'(MAX_BURST);
    if (remaining < LEN_WDTH'(MAX_BURST)) blen = remaining[8:0];
    if (to_4k < 13'(blen)) blen = to_4k[8:0];
  end

endmodule

// File: rtl/adc_axi_dma_wr_engine.sv
// AXI4 write-DMA engine: takes one (start, addr, len) job, moves ADC stream samples to DDR as
// INCR bursts split at MAX_BURST and 4 KB boundaries, one burst outstanding at a time.
// Ports:
//  sys_clk, sys_rst_n        clock, asynchronous active-low reset
//  cfg_wsoft_rst             synchronous abort back to idle (clears error flag)
//  cfg_wstart/waddr/wlen     job start pulse, byte address, byte length
//  cfg_widle                 1 = no job in progress (low for one cycle on a zero-beat job)
//  bus                       stream input and AXI4 AW/W/B channels (master modport)
//  sts_wr_err                sticky non-OKAY BRESP flag
// Build option: define ADC_DMA_WR_BRESP_CHK_EN to enable BRESP checking; otherwise
// sts_wr_err is tied to 0.
module adc_axi_dma_wr_engine
  import adc_dma_pkg::*;
#(
  parameter int unsigned LEN_WDTH  = 32,
  parameter int unsigned DATA_WDTH = 32,
  parameter int unsigned ADDR_WDTH = 32,
  parameter int unsigned MAX_BURST = 64
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    cfg_wsoft_rst,
  input  logic                    cfg_wstart,
  input  logic [ADDR_WDTH-1:0]    cfg_waddr,
  input  logic [LEN_WDTH-1:0]     cfg_wlen,
  output logic                    cfg_widle,
  adc_axi_dma_wr_engine_if.master bus,
  output logic                    sts_wr_err
);
  localparam int unsigned BeatShift = clog2(DATA_WDTH / 8);

  wr_state_e             state_q, state_d;
  logic [ADDR_WDTH-1:0]  addr_q, addr_d;
  logic [LEN_WDTH-1:0]   rem_q, rem_d;
  logic [8:0]            blen_q, blen_d;
  logic [8:0]            beat_q, beat_d;
  logic                  widle_q, widle_d;
  logic                  err_q, err_d;
  logic [8:0]            blen_calc;
  logic [LEN_WDTH-1:0]   job_beats;
  logic                  last_beat;

  adc_dma_burst_calc #(
    .LEN_WDTH  (LEN_WDTH),
    .DATA_WDTH (DATA_WDTH),
    .MAX_BURST (MAX_BURST)
  ) u_burst_calc (
    .addr      (addr_q[11:0]),
    .remaining (rem_q),
    .blen      (blen_calc)
  );

  assign job_beats = cfg_wlen >> BeatShift;
  assign last_beat = (beat_q == blen_q - 9'd1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    blen_d  = blen_q;
    beat_d  = beat_q;
    err_d   = err_q;

    bus.m_axi_awaddr  = addr_q;
    bus.m_axi_awlen   = 8'(blen_calc - 9'd1);
    bus.m_axi_awsize  = 3'(BeatShift);
    bus.m_axi_awburst = AXI_BURST_INCR;
    bus.m_axi_awvalid = 1'b0;
    bus.m_axi_wdata   = bus.s_axis_tdata;
    bus.m_axi_wstrb   = '1;
    bus.m_axi_wlast   = 1'b0;
    bus.m_axi_wvalid  = 1'b0;
    bus.s_axis_tready = 1'b0;
    bus.m_axi_bready  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cfg_wstart) begin
          addr_d = cfg_waddr;
          rem_d  = job_beats;
          beat_d = '0;
          if (job_beats != '0) state_d = StAw;
        end
      end
      StAw: begin
        bus.m_axi_awvalid = 1'b1;
        if (bus.m_axi_awready) begin
          blen_d  = blen_calc;
          beat_d  = '0;
          state_d = StW;
        end
      end
      StW: begin
        // Zero-latency pass-through between stream and W channel.
        bus.m_axi_wvalid  = bus.s_axis_tvalid;
        bus.s_axis_tready = bus.m_axi_wready;
        bus.m_axi_wlast   = last_beat;
        if (bus.s_axis_tvalid && bus.m_axi_wready) begin
          beat_d = beat_q + 9'd1;
          if (last_beat) begin
            beat_d  = '0;
            state_d = StB;
          end
        end
      end
      StB: begin
        bus.m_axi_bready = 1'b1;
        if (bus.m_axi_bvalid) begin
          addr_d = addr_q + (ADDR_WDTH'(blen_q) << BeatShift);
          rem_d  = rem_q - LEN_WDTH'(blen_q);
`ifdef ADC_DMA_WR_BRESP_CHK_EN
          if (bus.m_axi_bresp != 2'b00) err_d = 1'b1;
`endif
          state_d = (rem_q == LEN_WDTH'(blen_q)) ? StIdle : StAw;
        end
      end
      default: state_d = StIdle;
    endcase

    // Idle drops for the cycle after any accepted start, including zero-beat jobs.
    widle_d = (state_d == StIdle) && !((state_q == StIdle) && cfg_wstart);

    if (cfg_wsoft_rst) begin
      state_d           = StIdle;
      addr_d            = '0;
      rem_d             = '0;
      blen_d            = '0;
      beat_d            = '0;
      err_d             = 1'b0;
      widle_d           = 1'b1;
      bus.m_axi_awvalid = 1'b0;
      bus.m_axi_wvalid  = 1'b0;
      bus.m_axi_wlast   = 1'b0;
      bus.s_axis_tready = 1'b0;
      bus.m_axi_bready  = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      blen_q  <= '0;
      beat_q  <= '0;
      widle_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      blen_q  <= blen_d;
      beat_q  <= beat_d;
      widle_q <= widle_d;
      err_q   <= err_d;
    end
  end

  assign cfg_widle = widle_q;
`ifdef ADC_DMA_WR_BRESP_CHK_EN
  assign sts_wr_err = err_q;
`else
  assign sts_wr_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_axi_dma_wr_engine.sv
// Scoreboard bench for adc_axi_dma_wr_engine (DATA_WDTH=32, MAX_BURST=64).
module tb_adc_axi_dma_wr_engine;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        cfg_wsoft_rst = 1'b0;
  logic        cfg_wstart = 1'b0;
  logic [31:0] cfg_waddr = '0;
  logic [31:0] cfg_wlen = '0;
  logic        cfg_widle;
  logic        sts_wr_err;

  adc_axi_dma_wr_engine_if #(.DATA_WDTH(32), .ADDR_WDTH(32)) bus ();

  adc_axi_dma_wr_engine #(
    .LEN_WDTH  (32),
    .DATA_WDTH (32),
    .ADDR_WDTH (32),
    .MAX_BURST (64)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .cfg_wsoft_rst (cfg_wsoft_rst),
    .cfg_wstart    (cfg_wstart),
    .cfg_waddr     (cfg_waddr),
    .cfg_wlen      (cfg_wlen),
    .cfg_widle     (cfg_widle),
    .bus           (bus),
    .sts_wr_err    (sts_wr_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } aw_t;
  typedef struct packed { logic [31:0] data; logic last; } w_t;

  aw_t exp_aw[$];
  w_t  exp_w[$];

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          w_cnt = 0;
  int          b_idx = 0;
  int          b_cyc = 0;
  int          err_burst = -1;
  bit          stall_en = 1'b0;
  bit          b_pending = 1'b0;
  bit          b_seen = 1'b0;
  logic        prev_widle = 1'b1;
  logic        exp_err = 1'b0;
  logic [31:0] data_idx = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference burst split: min(remaining, 64, beats to the next 4 KB page).
  task automatic build_model(input logic [31:0] addr, input logic [31:0] len);
    int          rem, bl, to4k;
    logic [31:0] a, d;
    rem = int'(len >> 2);
    a   = addr;
    d   = data_idx;
    while (rem > 0) begin
      to4k = (4096 - int'(a % 4096)) / 4;
      bl = rem;
      if (bl > 64) bl = 64;
      if (bl > to4k) bl = to4k;
      exp_aw.push_back('{addr: a, len: 8'(bl - 1)});
      for (int i = 0; i < bl; i++) begin
        exp_w.push_back('{data: 32'hA500_0000 + d, last: (i == bl - 1)});
        d++;
      end
      a   = a + 32'(bl * 4);
      rem = rem - bl;
    end
  endtask

  task automatic soft_reset();
    @(posedge sys_clk); #2;
    cfg_wsoft_rst = 1'b1;
    @(posedge sys_clk); #2;
    cfg_wsoft_rst = 1'b0;
    exp_aw.delete();
    exp_w.delete();
  endtask

  task automatic start_job(input logic [31:0] addr, input logic [31:0] len);
    build_model(addr, len);
    w_cnt = 0;
    b_idx = 0;
    @(posedge sys_clk); #1;
    cfg_waddr  = addr;
    cfg_wlen   = len;
    cfg_wstart = 1'b1;
    @(posedge sys_clk); #1;
    cfg_wstart = 1'b0;
  endtask

  task automatic run_job(input logic [31:0] addr, input logic [31:0] len, input string tag);
    int k;
    start_job(addr, len);
    @(negedge sys_clk);
    chk({tag, "_widle_lo"}, 64'(cfg_widle), 64'd0);
    if ((len >> 2) == 0) begin
      @(negedge sys_clk);
      chk({tag, "_widle_1cyc"}, 64'(cfg_widle), 64'd1);
      chk({tag, "_no_aw"}, 64'(bus.m_axi_awvalid), 64'd0);
    end
    for (k = 0; k < 20000 && !cfg_widle; k++) @(negedge sys_clk);
    if (!cfg_widle) begin
      chk({tag, "_timeout"}, 64'd0, 64'd1);
      soft_reset();
    end
    chk({tag, "_aw_left"}, 64'(exp_aw.size()), 64'd0);
    chk({tag, "_w_left"}, 64'(exp_w.size()), 64'd0);
    chk({tag, "_beats"}, 64'(w_cnt), 64'(len >> 2));
  endtask

  // Bus slave, stream source and monitor. Handshakes are observed at negedge and complete
  // at the following posedge; inputs change 1 time unit after posedge.
  initial begin
    bit  aw_hs, w_hs, b_hs, s_hs, srst;
    aw_t ea;
    w_t  ew;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.m_axi_awready = 1'b0;
    bus.m_axi_wready  = 1'b0;
    bus.m_axi_bvalid  = 1'b0;
    bus.m_axi_bresp   = 2'b00;
    forever begin
      @(negedge sys_clk);
      cyc++;
      srst  = cfg_wsoft_rst;
      aw_hs = bus.m_axi_awvalid && bus.m_axi_awready && !srst;
      w_hs  = bus.m_axi_wvalid && bus.m_axi_wready && !srst;
      b_hs  = bus.m_axi_bvalid && bus.m_axi_bready && !srst;
      s_hs  = bus.s_axis_tvalid && bus.s_axis_tready;
      if (aw_hs) begin
        if (exp_aw.size() == 0) chk("aw_extra", 64'd1, 64'd0);
        else begin
          ea = exp_aw.pop_front();
          chk("awaddr", 64'(bus.m_axi_awaddr), 64'(ea.addr));
          chk("awlen", 64'(bus.m_axi_awlen), 64'(ea.len));
          chk("awsize", 64'(bus.m_axi_awsize), 64'd2);
          chk("awburst", 64'(bus.m_axi_awburst), 64'd1);
        end
      end
      if (w_hs) begin
        w_cnt++;
        if (exp_w.size() == 0) chk("w_extra", 64'd1, 64'd0);
        else begin
          ew = exp_w.pop_front();
          chk("wdata", 64'(bus.m_axi_wdata), 64'(ew.data));
          chk("wlast", 64'(bus.m_axi_wlast), 64'(ew.last));
          chk("wstrb", 64'(bus.m_axi_wstrb), 64'hF);
        end
      end
      if (b_hs) begin
        chk("sts_wr_err_at_b", 64'(sts_wr_err), 64'(exp_err));
`ifdef ADC_DMA_WR_BRESP_CHK_EN
        if (bus.m_axi_bresp != 2'b00) exp_err = 1'b1;
`endif
        b_seen = 1'b1;
        b_cyc  = cyc;
      end
      if (cfg_widle && !prev_widle && b_seen) begin
        chk("widle_rise_lat", 64'(cyc - b_cyc), 64'd1);
        b_seen = 1'b0;
      end
      prev_widle = cfg_widle;
      if (srst) begin
        b_seen  = 1'b0;
        exp_err = 1'b0;
      end

      @(posedge sys_clk); #1;
      if (s_hs) data_idx++;
      if (w_hs && bus.m_axi_wlast) b_pending = 1'b1;
      if (b_hs) begin
        bus.m_axi_bvalid = 1'b0;
        b_pending = 1'b0;
        b_idx++;
      end
      if (srst) begin
        bus.m_axi_bvalid = 1'b0;
        b_pending = 1'b0;
      end
      bus.s_axis_tdata  = 32'hA500_0000 + data_idx;
      bus.s_axis_tvalid = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.m_axi_awready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.m_axi_wready  = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!bus.m_axi_bvalid && b_pending && (!stall_en || $urandom_range(0, 1) == 1)) begin
        bus.m_axi_bvalid = 1'b1;
        bus.m_axi_bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
      end
    end
  end

  initial begin
    int   k;
    logic exp_sts;
    repeat (3) @(negedge sys_clk);
    chk("rst_widle", 64'(cfg_widle), 64'd1);
    chk("rst_awvalid", 64'(bus.m_axi_awvalid), 64'd0);
    chk("rst_wvalid", 64'(bus.m_axi_wvalid), 64'd0);
    chk("rst_bready", 64'(bus.m_axi_bready), 64'd0);
    chk("rst_tready", 64'(bus.s_axis_tready), 64'd0);
    chk("rst_wlast", 64'(bus.m_axi_wlast), 64'd0);
    chk("rst_err", 64'(sts_wr_err), 64'd0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Single 64-beat burst, then a 4 KB split, then zero-beat jobs.
    run_job(32'h9000_0000, 32'd256, "t1");
    run_job(32'h9000_0FF0, 32'd64, "t2");
    run_job(32'h9000_0100, 32'd0, "t3");
    run_job(32'h9000_0100, 32'd3, "t3b");

    // Random stalls on every handshake.
    stall_en = 1'b1;
    run_job(32'h9000_8000, 32'd1024, "t4");
    stall_en = 1'b0;

    // Abort in the middle of a burst, then restart elsewhere.
    start_job(32'h9000_4000, 32'd256);
    for (k = 0; k < 2000 && w_cnt < 9; k++) begin
      @(posedge sys_clk); #2;
    end
    chk("t5_reach_beat9", 64'(w_cnt >= 9), 64'd1);
    cfg_wsoft_rst = 1'b1;
    @(posedge sys_clk); #2;
    cfg_wsoft_rst = 1'b0;
    @(negedge sys_clk);
    chk("t5_widle", 64'(cfg_widle), 64'd1);
    chk("t5_wvalid", 64'(bus.m_axi_wvalid), 64'd0);
    chk("t5_awvalid", 64'(bus.m_axi_awvalid), 64'd0);
    chk("t5_bready", 64'(bus.m_axi_bready), 64'd0);
    chk("t5_beats_before", 64'(w_cnt), 64'd9);
    exp_aw.delete();
    exp_w.delete();
    run_job(32'h9000_5000, 32'd64, "t5b");

    // Error response on burst 2 of 3.
    err_burst = 1;
    run_job(32'h9000_6000, 32'd768, "t6");
`ifdef ADC_DMA_WR_BRESP_CHK_EN
    exp_sts = 1'b1;
`else
    exp_sts = 1'b0;
`endif
    chk("t6_err", 64'(sts_wr_err), 64'(exp_sts));
    err_burst = -1;
    soft_reset();
    @(negedge sys_clk);
    chk("t6_err_clr", 64'(sts_wr_err), 64'd0);
    run_job(32'h9000_7000, 32'd128, "t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
